// File: rtl/wb_adapter_pkg.sv
// wb_adapter_pkg: shared mode/granularity constants, FSM state type and width helper for the Wishbone adapters
package wb_adapter_pkg;
  localparam int MODE_CLASSIC = 0;
  localparam int MODE_PIPELINED = 1;
  localparam int GRAN_BYTE = 0;
  localparam int GRAN_WORD = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
  function automatic int log2_bytes(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/wb_dw_beat_gen.sv
// wb_dw_beat_gen: maps a latched wide request and a beat index to the narrow beat address, data and byte selects
module wb_dw_beat_gen
  import wb_adapter_pkg::*;
#(
  parameter int AW = 32,
  parameter int SL_DW = 64,
  parameter int MA_DW = 32,
  parameter int SL_GRAN = GRAN_WORD,
  parameter int MA_GRAN = GRAN_BYTE
) (
  input  logic [AW-1:0]      adr,
  input  logic [SL_DW-1:0]   dat,
  input  logic [SL_DW/8-1:0] sel,
  input  logic [2:0]         beat,
  output logic [AW-1:0]      b_adr,
  output logic [MA_DW-1:0]   b_dat,
  output logic [MA_DW/8-1:0] b_sel
);
  localparam int SB = log2_bytes(SL_DW);
  localparam int MB = log2_bytes(MA_DW);
  logic [AW-1:0] base, byte_adr;
  always_comb begin
    base = SL_GRAN == GRAN_WORD ? adr << SB : (adr >> SB) << SB;
    byte_adr = base + ({{(AW-3){1'b0}}, beat} << MB);
    b_adr = MA_GRAN == GRAN_WORD ? byte_adr >> MB : byte_adr;
    b_dat = dat[int'(beat) * MA_DW +: MA_DW];
    b_sel = sel[int'(beat) * (MA_DW / 8) +: MA_DW / 8];
  end
endmodule

// File: rtl/wb_dw_adapter.sv
// wb_dw_adapter: splits wide Wishbone accesses into pipelined narrow beats; WB_DW_ADAPTER_SKIP_EMPTY_EN skips all-zero-sel beats
module wb_dw_adapter
  import wb_adapter_pkg::*;
#(
  parameter int AW = 32,
  parameter int SL_DW = 64,
  parameter int MA_DW = 32,
  parameter int SL_MODE = MODE_CLASSIC,
  parameter int SL_GRAN = GRAN_WORD,
  parameter int MA_GRAN = GRAN_BYTE
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [AW-1:0]      sl_adr_i,
  input  logic [SL_DW-1:0]   sl_dat_i,
  input  logic [SL_DW/8-1:0] sl_sel_i,
  input  logic               sl_we_i,
  input  logic               sl_cyc_i,
  input  logic               sl_stb_i,
  output logic [SL_DW-1:0]   sl_dat_o,
  output logic               sl_ack_o,
  output logic               sl_err_o,
  output logic               sl_stall_o,
  output logic [AW-1:0]      ma_adr_o,
  output logic [MA_DW-1:0]   ma_dat_o,
  output logic [MA_DW/8-1:0] ma_sel_o,
  output logic               ma_we_o,
  output logic               ma_cyc_o,
  output logic               ma_stb_o,
  input  logic [MA_DW-1:0]   ma_dat_i,
  input  logic               ma_ack_i,
  input  logic               ma_err_i,
  input  logic               ma_rty_i,
  input  logic               ma_stall_i
);
  localparam int R = SL_DW / MA_DW;
  localparam int MS = MA_DW / 8;
  localparam logic [3:0] RN = 4'(R);
  if (SL_DW != R * MA_DW || !(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_ratio
    $error("wb_dw_adapter: SL_DW/MA_DW must be 1, 2, 4 or 8");
  end
  state_t state, state_n;
  logic [AW-1:0] adr_q, g_adr, b_adr;
  logic [SL_DW-1:0] dat_q, g_dat, rdat_q, rdat_n;
  logic [SL_DW/8-1:0] sel_q, g_sel;
  logic [MA_DW-1:0] b_dat;
  logic [MA_DW/8-1:0] b_sel;
  logic [R-1:0] nz;
  logic [3:0] bp_q, bp_n, ap_q, ap_n, nb;
  logic [2:0] bi;
  logic we_q, g_we, lat, ld, abort, cyc_n, stb_n, ack_n, err_n;
  // Pointers walk beats in order; both land on R once every (non-skipped) beat is done.
  function automatic logic [3:0] next_beat(input logic [R-1:0] m, input logic [3:0] from);
    logic [3:0] n;
    n = RN;
    for (int k = R - 1; k >= 0; k--) if (k >= int'(from) && m[k]) n = 4'(k);
    return n;
  endfunction
  always_comb begin
    g_adr = state == IDLE ? sl_adr_i : adr_q;
    g_dat = state == IDLE ? sl_dat_i : dat_q;
    g_sel = state == IDLE ? sl_sel_i : sel_q;
    g_we = state == IDLE ? sl_we_i : we_q;
    abort = !sl_cyc_i || (SL_MODE == MODE_CLASSIC && !sl_stb_i);
    bi = nb != RN ? nb[2:0] : 3'd0;
`ifdef WB_DW_ADAPTER_SKIP_EMPTY_EN
    for (int k = 0; k < R; k++) nz[k] = |g_sel[k*MS +: MS];
`else
    nz = '1;
`endif
  end
  always_comb begin
    state_n = state;
    bp_n = bp_q;
    ap_n = ap_q;
    rdat_n = rdat_q;
    nb = bp_q;
    lat = 1'b0;
    ld = 1'b0;
    cyc_n = ma_cyc_o;
    stb_n = ma_stb_o;
    ack_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (sl_cyc_i && sl_stb_i) begin
        lat = 1'b1;
        rdat_n = '0;
        nb = next_beat(nz, 4'd0);
        bp_n = nb;
        ap_n = nb;
        ld = nb != RN;
        cyc_n = ld;
        stb_n = ld;
        ack_n = !ld;
        state_n = ld ? ISSUE : RESP;
      end
      ISSUE, DRAIN: begin
        if (ma_ack_i && !we_q && ap_q != RN) rdat_n[ap_q * MA_DW +: MA_DW] = ma_dat_i;
        ap_n = ma_ack_i ? next_beat(nz, ap_q + 4'd1) : ap_q;
        bp_n = state == ISSUE && !ma_stall_i ? next_beat(nz, bp_q + 4'd1) : bp_q;
        nb = bp_n;
        ld = state == ISSUE && bp_n != RN;
        stb_n = ld;
        if (abort) begin
          state_n = IDLE;
          cyc_n = 1'b0;
          stb_n = 1'b0;
        end else if (ma_err_i || ma_rty_i) begin
          state_n = RESP;
          cyc_n = 1'b0;
          stb_n = 1'b0;
          err_n = 1'b1;
        end else if (ap_n == RN) begin
          state_n = RESP;
          cyc_n = 1'b0;
          stb_n = 1'b0;
          ack_n = 1'b1;
        end else if (bp_n == RN) state_n = DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  wb_dw_beat_gen #(
    .AW(AW), .SL_DW(SL_DW), .MA_DW(MA_DW), .SL_GRAN(SL_GRAN), .MA_GRAN(MA_GRAN)
  ) u_beat (
    .adr(g_adr), .dat(g_dat), .sel(g_sel), .beat(bi),
    .b_adr(b_adr), .b_dat(b_dat), .b_sel(b_sel)
  );
  assign sl_stall_o = state != IDLE;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      bp_q <= '0;
      ap_q <= '0;
      rdat_q <= '0;
      ma_adr_o <= '0;
      ma_dat_o <= '0;
      ma_sel_o <= '0;
      ma_we_o <= 1'b0;
      ma_cyc_o <= 1'b0;
      ma_stb_o <= 1'b0;
      sl_ack_o <= 1'b0;
      sl_err_o <= 1'b0;
      sl_dat_o <= '0;
    end else begin
      state <= state_n;
      bp_q <= bp_n;
      ap_q <= ap_n;
      rdat_q <= rdat_n;
      if (lat) begin
        adr_q <= sl_adr_i;
        dat_q <= sl_dat_i;
        sel_q <= sl_sel_i;
        we_q <= sl_we_i;
      end
      if (ld) begin
        ma_adr_o <= b_adr;
        ma_dat_o <= b_dat;
        ma_sel_o <= b_sel;
        ma_we_o <= g_we;
      end
      ma_cyc_o <= cyc_n;
      ma_stb_o <= stb_n;
      sl_ack_o <= ack_n;
      sl_err_o <= err_n;
      sl_dat_o <= ack_n && !g_we ? rdat_n : '0;
    end
  end
endmodule
